// File: rtl/maxnet_seq.sv
// Maxnet winner-take-all sequencer over four fp32 activations.
// Drives one shared external FPU through a single-outstanding req/ack handshake.
module maxnet_seq #(
  parameter int unsigned MAX_ITER = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] eps,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic [31:0] a3,
  input  logic [31:0] a4,
  output logic        finish,
  output logic        overflow,
  output logic [31:0] out,
  output logic [1:0]  win_idx,
  output logic [7:0]  iter_cnt,
  output logic        fpu_req,
  output logic        fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic        fpu_ack,
  input  logic [31:0] fpu_res,
  input  logic        fpu_ovf
);

  typedef enum logic [3:0] {
    StIdle, StLoad, StSum, StSub, StMul, StAdd, StCommit, StCheck, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q [4];
  logic [31:0] a_d [4];
  logic [31:0] n_q [4];
  logic [31:0] n_d [4];
  logic [31:0] eps_q, eps_d, s_q, s_d, t_q, t_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d, out_q, out_d;
  logic [1:0]  idx_q, idx_d, win_q, win_d;
  logic [7:0]  iter_q, iter_d;
  logic        req_q, req_d, op_q, op_d, fin_q, fin_d, ovf_q, ovf_d;

  logic        op_state, start_ok, accept, res_bad, iter_max;
  logic [2:0]  nz_cnt;
  logic [1:0]  nz_idx;

  function automatic logic [31:0] relu(input logic [31:0] x);
    return x[31] ? 32'h0 : x;
  endfunction

  assign op_state = (state_q == StSum) || (state_q == StSub) ||
                    (state_q == StMul) || (state_q == StAdd);
  assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
  // Acks are only meaningful while our own request is outstanding.
  assign accept   = op_state && req_q && fpu_ack;
  assign res_bad  = fpu_ovf || (fpu_res[30:23] == 8'hFF);
  assign iter_max = (iter_q == 8'(MAX_ITER));

  always_comb begin
    nz_cnt = '0;
    nz_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (a_q[i][30:0] != '0) begin
        nz_cnt = nz_cnt + 3'd1;
        nz_idx = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StLoad;
      StLoad:         state_d = StCheck;
      StSum: if (accept) state_d = res_bad ? StDone : ((idx_q == 2'd2) ? StSub : StSum);
      StSub: if (accept) state_d = res_bad ? StDone : StMul;
      StMul: if (accept) state_d = res_bad ? StDone : StAdd;
      StAdd: if (accept) state_d = res_bad ? StDone : ((idx_q == 2'd3) ? StCommit : StSub);
      StCommit:       state_d = StCheck;
      StCheck:        state_d = ((nz_cnt <= 3'd1) || iter_max) ? StDone : StSum;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    eps_d  = eps_q;
    a_d    = a_q;
    n_d    = n_q;
    s_d    = s_q;
    t_d    = t_q;
    idx_d  = idx_q;
    iter_d = iter_q;
    req_d  = req_q;
    op_d   = op_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    fin_d  = fin_q;
    ovf_d  = ovf_q;
    out_d  = out_q;
    win_d  = win_q;

    if (start_ok) begin
      eps_d  = eps;
      a_d[0] = relu(a1);
      a_d[1] = relu(a2);
      a_d[2] = relu(a3);
      a_d[3] = relu(a4);
      idx_d  = '0;
      iter_d = '0;
      fin_d  = 1'b0;
      ovf_d  = 1'b0;
      out_d  = '0;
      win_d  = '0;
    end

    // Each op spends one cycle with req low, then holds req until the ack.
    if (op_state && !req_q) begin
      req_d = 1'b1;
      op_d  = (state_q == StMul);
      unique case (state_q)
        StSum: begin
          opa_d = (idx_q == 2'd0) ? a_q[0] : s_q;
          opb_d = a_q[idx_q + 2'd1];
        end
        StSub: begin
          opa_d = s_q;
          opb_d = a_q[idx_q] ^ 32'h8000_0000;
        end
        StMul: begin
          opa_d = eps_q;
          opb_d = t_q;
        end
        default: begin
          opa_d = a_q[idx_q];
          opb_d = t_q;
        end
      endcase
    end else if (accept) begin
      req_d = 1'b0;
      if (res_bad) begin
        fin_d = 1'b1;
        ovf_d = 1'b1;
        out_d = '0;
        win_d = '0;
      end else begin
        unique case (state_q)
          StSum: begin
            s_d   = fpu_res;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
          end
          StSub, StMul: t_d = fpu_res;
          default: begin
            n_d[idx_q] = relu(fpu_res);
            idx_d      = idx_q + 2'd1;
          end
        endcase
      end
    end

    if (state_q == StCommit) begin
      a_d    = n_q;
      iter_d = iter_q + 8'd1;
    end

    if (state_q == StCheck) begin
      if (nz_cnt <= 3'd1) begin
        fin_d = 1'b1;
        ovf_d = 1'b0;
        out_d = (nz_cnt == 3'd1) ? a_q[nz_idx] : 32'h0;
        win_d = (nz_cnt == 3'd1) ? nz_idx : 2'd0;
      end else if (iter_max) begin
        fin_d = 1'b1;
        ovf_d = 1'b1;
        out_d = '0;
        win_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= '0;
        n_q[i] <= '0;
      end
      eps_q  <= '0;
      s_q    <= '0;
      t_q    <= '0;
      idx_q  <= '0;
      iter_q <= '0;
      req_q  <= 1'b0;
      op_q   <= 1'b0;
      opa_q  <= '0;
      opb_q  <= '0;
      fin_q  <= 1'b0;
      ovf_q  <= 1'b0;
      out_q  <= '0;
      win_q  <= '0;
    end else begin
      a_q    <= a_d;
      n_q    <= n_d;
      eps_q  <= eps_d;
      s_q    <= s_d;
      t_q    <= t_d;
      idx_q  <= idx_d;
      iter_q <= iter_d;
      req_q  <= req_d;
      op_q   <= op_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      fin_q  <= fin_d;
      ovf_q  <= ovf_d;
      out_q  <= out_d;
      win_q  <= win_d;
    end
  end

  assign finish   = fin_q;
  assign overflow = ovf_q;
  assign out      = out_q;
  assign win_idx  = win_q;
  assign iter_cnt = iter_q;
  assign fpu_req  = req_q;
  assign fpu_op   = op_q;
  assign fpu_a    = opa_q;
  assign fpu_b    = opb_q;

endmodule

// File: tb/tb_maxnet_seq.sv
// Bench for maxnet_seq: fp32 FPU responder with latency 3, real-arithmetic Maxnet model,
// per-cycle handshake checks and directed scenarios.
module tb_maxnet_seq;
  localparam int L = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] eps, a1, a2, a3, a4;
  logic        start_s [2];
  logic        fin_w [2];
  logic        ovf_w [2];
  logic        req_w [2];
  logic        op_w [2];
  logic [31:0] out_w [2];
  logic [31:0] fa_w [2];
  logic [31:0] fb_w [2];
  logic [1:0]  win_w [2];
  logic [7:0]  iter_w [2];
  logic        ack_r [2] = '{1'b0, 1'b0};
  logic        fovf_r [2] = '{1'b0, 1'b0};
  logic [31:0] res_r [2] = '{32'h0, 32'h0};

  int          inj_at [2] = '{0, 0};
  int          ack_n [2] = '{0, 0};
  int          req_n [2] = '{0, 0};
  logic        req_p [2] = '{1'b0, 1'b0};
  logic        busy [2] = '{1'b0, 1'b0};
  int          cnt [2] = '{0, 0};
  logic        op_l [2] = '{1'b0, 1'b0};
  logic [31:0] a_l [2] = '{32'h0, 32'h0};
  logic [31:0] b_l [2] = '{32'h0, 32'h0};

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_out, exp_win;
  logic        exp_ovf;
  int          exp_iter, exp_ops, exp_cyc, req_base;
  time         t0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    maxnet_seq #(.MAX_ITER(g == 0 ? 64 : 2)) u_dut (
      .clk(clk), .rst(rst), .start(start_s[g]), .eps(eps),
      .a1(a1), .a2(a2), .a3(a3), .a4(a4),
      .finish(fin_w[g]), .overflow(ovf_w[g]), .out(out_w[g]), .win_idx(win_w[g]),
      .iter_cnt(iter_w[g]), .fpu_req(req_w[g]), .fpu_op(op_w[g]), .fpu_a(fa_w[g]),
      .fpu_b(fb_w[g]), .fpu_ack(ack_r[g]), .fpu_res(res_r[g]), .fpu_ovf(fovf_r[g])
    );
  end

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'h0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [24:0] mr;
    logic [28:0] low;
    int          ex;
    d = $realtobits(r);
    if (d[62:0] == '0) return {d[63], 31'b0};
    ex = int'(d[62:52]) - 896;
    if (ex <= 0) return {d[63], 31'b0};
    mr  = {2'b01, d[51:29]};
    low = d[28:0];
    if (low > 29'h1000_0000 || (low == 29'h1000_0000 && mr[0])) mr = mr + 25'd1;
    if (mr[24]) begin
      ex = ex + 1;
      mr = mr >> 1;
    end
    if (ex >= 255) return {d[63], 8'hFF, 23'b0};
    return {d[63], 8'(ex), mr[22:0]};
  endfunction

  function automatic logic [31:0] f_add(input logic [31:0] x, input logic [31:0] y);
    return r2f(f2r(x) + f2r(y));
  endfunction

  function automatic logic [31:0] f_mul(input logic [31:0] x, input logic [31:0] y);
    return r2f(f2r(x) * f2r(y));
  endfunction

  // FPU responder: ack L cycles after req rises; keeps going across a reset on purpose.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      ack_r[k]  <= 1'b0;
      fovf_r[k] <= 1'b0;
      req_p[k]  <= req_w[k];
      if (req_w[k] && !req_p[k]) req_n[k] <= req_n[k] + 1;
      if (busy[k]) begin
        if (cnt[k] == L - 1) begin
          ack_r[k]  <= 1'b1;
          res_r[k]  <= op_l[k] ? f_mul(a_l[k], b_l[k]) : f_add(a_l[k], b_l[k]);
          fovf_r[k] <= (inj_at[k] != 0) && (ack_n[k] + 1 == inj_at[k]);
          ack_n[k]  <= ack_n[k] + 1;
          busy[k]   <= 1'b0;
        end else begin
          cnt[k] <= cnt[k] + 1;
        end
      end else if (req_w[k] && !ack_r[k]) begin
        busy[k] <= 1'b1;
        cnt[k]  <= 1;
        op_l[k] <= op_w[k];
        a_l[k]  <= fa_w[k];
        b_l[k]  <= fb_w[k];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, expv);
    end
  endtask

  function automatic bit fp_bad(input logic [31:0] r, input int ops, input int inj);
    return (r[30:23] == 8'hFF) || (inj != 0 && ops == inj);
  endfunction

  // Maxnet computed directly with fp32 rounding; inj = ordinal of the ack that reports overflow.
  task automatic model_run(input logic [31:0] e, input logic [31:0] v0, input logic [31:0] v1,
                           input logic [31:0] v2, input logic [31:0] v3, input int maxi,
                           input int inj);
    logic [31:0] a [4];
    logic [31:0] n [4];
    logic [31:0] s, r;
    int          nz, w, it, ops;
    bit          done, bad;
    a[0] = v0; a[1] = v1; a[2] = v2; a[3] = v3;
    for (int i = 0; i < 4; i++) if (a[i][31]) a[i] = 32'h0;
    it = 0; ops = 0; done = 0; bad = 0;
    while (!done) begin
      nz = 0; w = 0;
      for (int i = 0; i < 4; i++) if (a[i][30:0] != '0) begin nz++; w = i; end
      if (nz <= 1) begin
        done = 1; exp_ovf = 1'b0;
        exp_out = (nz == 1) ? a[w] : 32'h0;
        exp_win = (nz == 1) ? w : 0;
      end else if (it == maxi) begin
        done = 1; exp_ovf = 1'b1; exp_out = 32'h0; exp_win = 0;
      end else begin
        s = a[0];
        for (int i = 1; i < 4 && !bad; i++) begin
          s = f_add(s, a[i]); ops++; bad = fp_bad(s, ops, inj);
        end
        for (int i = 0; i < 4 && !bad; i++) begin
          r = f_add(s, a[i] ^ 32'h8000_0000); ops++; bad = fp_bad(r, ops, inj);
          if (!bad) begin r = f_mul(e, r); ops++; bad = fp_bad(r, ops, inj); end
          if (!bad) begin r = f_add(a[i], r); ops++; bad = fp_bad(r, ops, inj); end
          n[i] = r[31] ? 32'h0 : r;
        end
        if (bad) begin
          done = 1; exp_ovf = 1'b1; exp_out = 32'h0; exp_win = 0;
        end else begin
          a = n; it++;
        end
      end
    end
    exp_iter = it;
    exp_ops  = ops;
    exp_cyc  = 3 + ops * (L + 2) + 2 * it;
  endtask

  task automatic launch(input int k, input logic [31:0] e, input logic [31:0] v0,
                        input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] v3,
                        input int maxi, input int inj);
    @(posedge clk); #1;
    eps = e; a1 = v0; a2 = v1; a3 = v2; a4 = v3;
    start_s[k] = 1'b1;
    model_run(e, v0, v1, v2, v3, maxi, inj);
    req_base = req_n[k];
    @(posedge clk);
    t0 = $time;
    #1 start_s[k] = 1'b0;
  endtask

  task automatic finish_run(input int k, input string tag);
    bit          seen;
    logic        rq_p, ack_p, op_p;
    logic [31:0] fa_p, fb_p;
    int          cyc;
    seen = 0; rq_p = 1'b0; ack_p = 1'b0; op_p = 1'b0; fa_p = '0; fb_p = '0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      @(negedge clk);
      if (rq_p && req_w[k]) begin
        chk({tag, "_hs_op"}, op_w[k], op_p);
        chk({tag, "_hs_a"}, fa_w[k], fa_p);
        chk({tag, "_hs_b"}, fb_w[k], fb_p);
      end
      if (ack_p) chk({tag, "_req_drop"}, req_w[k], 1'b0);
      rq_p = req_w[k]; op_p = op_w[k]; fa_p = fa_w[k]; fb_p = fb_w[k]; ack_p = ack_r[k];
      if (fin_w[k]) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout: finish not seen within 4000 cycles", tag);
      return;
    end
    cyc = int'(($time - t0 - 5) / 10) + 1;
    chk({tag, "_cycles"}, cyc, exp_cyc);
    chk({tag, "_out"}, out_w[k], exp_out);
    chk({tag, "_win"}, win_w[k], exp_win);
    chk({tag, "_ovf"}, ovf_w[k], exp_ovf);
    chk({tag, "_iter"}, iter_w[k], exp_iter);
    chk({tag, "_reqs"}, req_n[k] - req_base, exp_ops);
  endtask

  task automatic check_quiet(input int k, input string tag);
    chk({tag, "_finish"}, fin_w[k], 0);
    chk({tag, "_overflow"}, ovf_w[k], 0);
    chk({tag, "_out"}, out_w[k], 0);
    chk({tag, "_win"}, win_w[k], 0);
    chk({tag, "_iter"}, iter_w[k], 0);
    chk({tag, "_req"}, req_w[k], 0);
    chk({tag, "_op"}, op_w[k], 0);
    chk({tag, "_fa"}, fa_w[k], 0);
    chk({tag, "_fb"}, fb_w[k], 0);
  endtask

  localparam logic [31:0] E1 = 32'hBE4C_CCCD;
  localparam logic [31:0] V0 = 32'h3E4C_CCCD, V1 = 32'h3ECC_CCCD;
  localparam logic [31:0] V2 = 32'h3F19_999A, V3 = 32'h3F4C_CCCD;

  initial begin
    real d;
    bit  seen;
    rst = 1'b0; start_s = '{1'b0, 1'b0};
    eps = '0; a1 = '0; a2 = '0; a3 = '0; a4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet(0, "rst0");
    check_quiet(1, "rst1");
    @(posedge clk); #1 rst = 1'b1;

    // Main convergence case.
    launch(0, E1, V0, V1, V2, V3, 64, 0);
    finish_run(0, "s1");
    chk("s1_lit_iter", iter_w[0], 5);
    chk("s1_lit_win", win_w[0], 3);
    chk("s1_lit_ovf", ovf_w[0], 0);
    chk("s1_lit_reqs", req_n[0] - req_base, 75);
    d = f2r(out_w[0]) - 0.420864;
    if (d < 0.0) d = -d;
    checks++;
    if (d >= 1e-5) begin
      errors++;
      $display("FAIL s1_lit_out: got %h expected about 0.420864", out_w[0]);
    end

    // Already converged after ReLU: no FPU traffic.
    launch(0, E1, 32'h0, 32'hBF80_0000, 32'h3F00_0000, 32'h0, 64, 0);
    finish_run(0, "s2");
    chk("s2_lit_out", out_w[0], 32'h3F00_0000);
    chk("s2_lit_win", win_w[0], 2);
    chk("s2_lit_cycles", int'(($time - t0 - 5) / 10) + 1, 3);
    chk("s2_lit_reqs", req_n[0] - req_base, 0);

    // Iteration limit on the MAX_ITER=2 instance.
    launch(1, 32'hBC23_D70A, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 2, 0);
    finish_run(1, "s3");
    chk("s3_lit_ovf", ovf_w[1], 1);
    chk("s3_lit_iter", iter_w[1], 2);

    // FPU overflow on the 4th ack.
    inj_at[0] = ack_n[0] + 4;
    launch(0, E1, V0, V1, V2, V3, 64, 4);
    finish_run(0, "s4");
    chk("s4_lit_ovf", ovf_w[0], 1);
    chk("s4_lit_out", out_w[0], 0);
    repeat (10) @(negedge clk);
    chk("s4_no_more_req", req_n[0] - req_base, 4);
    inj_at[0] = 0;

    // Reset during MUL with the ack landing the cycle after reset.
    launch(0, E1, V0, V1, V2, V3, 64, 0);
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (req_w[0] && op_w[0]) seen = 1;
    end
    chk("s5_mul_seen", seen, 1);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check_quiet(0, "s5a");
    repeat (5) @(negedge clk);
    check_quiet(0, "s5b");
    launch(0, E1, V0, V1, V2, V3, 64, 0);
    finish_run(0, "s5");

    // start (with different inputs) during SUM must be ignored.
    launch(0, E1, V0, V1, V2, V3, 64, 0);
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (req_w[0]) seen = 1;
    end
    chk("s6_sum_seen", seen, 1);
    @(posedge clk); #1;
    start_s[0] = 1'b1; a1 = 32'h0; a2 = 32'hBF80_0000; a3 = 32'h3F00_0000; a4 = 32'h0;
    @(posedge clk); #1 start_s[0] = 1'b0;
    finish_run(0, "s6");
    chk("s6_lit_win", win_w[0], 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
